// File: rtl/scaled_mult_seq.sv
// Sequential shift-add multiplier for the scaled fixed-point word {signed mantissa, unsigned scale}.
// Normalises the product into MW mantissa bits, with optional round-half-up and saturation.
module scaled_mult_seq #(
  parameter  int MW         = 13,
  parameter  int SW         = 3,
  parameter  int ROUND_MODE = 0,
  localparam int W          = MW + SW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         ovf
);

  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW + 1);
  localparam logic [SW:0]   SMAX_V = {1'b0, {SW{1'b1}}};
  localparam logic [SW:0]   ONE_S  = {{SW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] ONE_P  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] ONE_M  = {{(MW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          neg_q, neg_d;
  logic [MW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW:0]   scale_q, scale_d;
  logic          guard_q, guard_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [MW-1:0] mant_a_s, mant_b_s, abs_a_s, abs_b_s;
  logic [MW:0]   sum_s;
  logic [PW-1:0] step_s, rounded_s;
  logic          round_inc_s, scale_big_s, scale_nz_s;

  // A value fits when every bit above the mantissa sign bit equals that sign bit.
  function automatic logic fits(input logic [PW-1:0] v);
    return (&v[PW-1:MW-1]) | (~|v[PW-1:MW-1]);
  endfunction

  function automatic logic [PW-1:0] asr1(input logic [PW-1:0] v);
    return {v[PW-1], v[PW-1:1]};
  endfunction

  function automatic logic [MW-1:0] sat(input logic neg);
    return neg ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
  endfunction

  assign mant_a_s    = a[W-1:SW];
  assign mant_b_s    = b[W-1:SW];
  assign abs_a_s     = mant_a_s[MW-1] ? (~mant_a_s + ONE_M) : mant_a_s;
  assign abs_b_s     = mant_b_s[MW-1] ? (~mant_b_s + ONE_M) : mant_b_s;
  // Right-shifting accumulator: add into the upper half, then shift the whole word down.
  assign sum_s       = {1'b0, acc_q[PW-1:MW]} + {1'b0, (mplier_q[0] ? mcand_q : {MW{1'b0}})};
  assign step_s      = {sum_s, acc_q[MW-1:1]};
  assign round_inc_s = (ROUND_MODE == 1) ? guard_q : 1'b0;
  assign rounded_s   = round_inc_s ? (acc_q + ONE_P) : acc_q;
  assign scale_big_s = scale_q > SMAX_V;
  assign scale_nz_s  = |scale_q;

  // Next-state and datapath computation for every register.
  always_comb begin
    state_d    = state_q;
    neg_d      = neg_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    scale_d    = scale_q;
    guard_d    = guard_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          neg_d    = mant_a_s[MW-1] ^ mant_b_s[MW-1];
          mcand_d  = abs_a_s;
          mplier_d = abs_b_s;
          scale_d  = {1'b0, a[SW-1:0]} + {1'b0, b[SW-1:0]};
          acc_d    = {PW{1'b0}};
          cnt_d    = {CW{1'b0}};
          guard_d  = 1'b0;
          state_d  = S_MUL;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_MUL: begin
        mplier_d = {1'b0, mplier_q[MW-1:1]};
        cnt_d    = cnt_q + ONE_C;
        if (cnt_q == CW'(MW - 1)) begin
          acc_d   = neg_q ? (~step_s + ONE_P) : step_s;
          state_d = S_NORM;
        end else begin
          acc_d   = step_s;
        end
      end
      S_NORM: begin
        if ((!fits(acc_q) || scale_big_s) && scale_nz_s) begin
          acc_d   = asr1(acc_q);
          scale_d = scale_q - ONE_S;
          guard_d = acc_q[0];
        end else if (fits(acc_q) && !scale_big_s) begin
          if (fits(rounded_s)) begin
            out_data_d = {rounded_s[MW-1:0], scale_q[SW-1:0]};
            ovf_d      = 1'b0;
            state_d    = S_DONE;
          end else if (scale_nz_s) begin
            acc_d      = asr1(rounded_s);
            scale_d    = scale_q - ONE_S;
            guard_d    = 1'b0;
          end else begin
            out_data_d = {sat(rounded_s[PW-1]), {SW{1'b0}}};
            ovf_d      = 1'b1;
            state_d    = S_DONE;
          end
        end else begin
          out_data_d = {sat(acc_q[PW-1]), {SW{1'b0}}};
          ovf_d      = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      neg_q       <= 1'b0;
      mcand_q     <= {MW{1'b0}};
      mplier_q    <= {MW{1'b0}};
      acc_q       <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      scale_q     <= {(SW+1){1'b0}};
      guard_q     <= 1'b0;
      out_data_q  <= {W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      neg_q       <= neg_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      scale_q     <= scale_d;
      guard_q     <= guard_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_scaled_mult_seq.sv
// Bench for scaled_mult_seq: one instance per rounding mode, fixed vectors, corner sequences
// and random operands checked against an arithmetic reference model.
module tb_scaled_mult_seq;

  localparam int MW = 13;
  localparam int SW = 3;
  localparam int W  = MW + SW;
  localparam int SMAX = (1 << SW) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready0, out_valid0, ovf0;
  logic         in_ready1, out_valid1, ovf1;
  logic [W-1:0] out_data0, out_data1;

  int n_pass  = 0;
  int n_total = 0;

  scaled_mult_seq #(.MW(MW), .SW(SW), .ROUND_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .ovf(ovf0)
  );

  scaled_mult_seq #(.MW(MW), .SW(SW), .ROUND_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e0;
    logic         o0;
    int           k0;
    logic [W-1:0] e1;
    logic         o1;
    int           k1;
  } vec_t;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: exact integer product, then apply the normalisation rules until a result emerges.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb2, input int rm,
                       output logic [W-1:0] d, output logic o, output int k);
    longint p, r, lo, hi;
    int     s;
    bit     g, done;
    logic [MW-1:0] m;
    lo = -(longint'(1) << (MW - 1));
    hi = (longint'(1) << (MW - 1)) - 1;
    p  = longint'($signed(ta[W-1:SW])) * longint'($signed(tb2[W-1:SW]));
    s  = int'(ta[SW-1:0]) + int'(tb2[SW-1:0]);
    g = 1'b0; k = 0; done = 1'b0; d = '0; o = 1'b0;
    while (!done) begin
      if ((p < lo || p > hi || s > SMAX) && s > 0) begin
        g = p[0]; p = p >>> 1; s--; k++;
      end else if (p >= lo && p <= hi) begin
        r = p + ((rm == 1 && g) ? 1 : 0);
        if (r > hi && s > 0) begin
          p = r >>> 1; g = 1'b0; s--; k++;
        end else if (r > hi) begin
          m = {1'b0, {(MW-1){1'b1}}}; d = {m, {SW{1'b0}}}; o = 1'b1; done = 1'b1;
        end else begin
          m = r[MW-1:0]; d = {m, s[SW-1:0]}; o = 1'b0; done = 1'b1;
        end
      end else begin
        m = (p < 0) ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
        d = {m, {SW{1'b0}}}; o = 1'b1; done = 1'b1;
      end
    end
  endtask

  // One transaction on both instances; hold > 0 keeps out_ready low that many cycles after the result.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input int hold, input logic [W-1:0] e0, input logic o0, input int k0,
                        input logic [W-1:0] e1, input logic o1, input int k1);
    int edges, lat0, lat1;
    logic [W-1:0] d0, d1;
    logic v0, v1, f0, f1;
    @(negedge clk);
    check({nm, " in_ready"}, {in_ready0, in_ready1}, 2'b11);
    a = ta; b = tbv; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    edges = 0; v0 = 1'b0; v1 = 1'b0; lat0 = -1; lat1 = -1;
    d0 = '0; d1 = '0; f0 = 1'b0; f1 = 1'b0;
    while (!(v0 && v1) && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (!v0 && out_valid0) begin v0 = 1'b1; lat0 = edges; d0 = out_data0; f0 = ovf0; end
      if (!v1 && out_valid1) begin v1 = 1'b1; lat1 = edges; d1 = out_data1; f1 = ovf1; end
    end
    check({nm, " data0"}, d0, e0);
    check({nm, " ovf0"}, f0, o0);
    check({nm, " lat0"}, lat0, MW + k0 + 1);
    check({nm, " data1"}, d1, e1);
    check({nm, " ovf1"}, f1, o1);
    check({nm, " lat1"}, lat1, MW + k1 + 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({nm, " hold state"}, {out_valid0, in_ready0}, 2'b10);
      check({nm, " hold data"}, {out_data0, ovf0}, {e0, o0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, " drain"}, {out_valid0, in_ready0, out_valid1, in_ready1}, 4'b0101);
  endtask

  initial begin
    vec_t vecs[6];
    logic [W-1:0] ra, rb, e0, e1;
    logic o0, o1;
    int k0, k1;

    vecs[0] = '{16'h0039, 16'h02A4, 16'h1265, 1'b0, 0, 16'h1265, 1'b0, 0};
    vecs[1] = '{16'h051D, 16'h058D, 16'h70B7, 1'b0, 3, 16'h70B7, 1'b0, 3};
    vecs[2] = '{16'h1E07, 16'hFC07, 16'hE207, 1'b0, 7, 16'hE207, 1'b0, 7};
    vecs[3] = '{16'h7FF8, 16'h7FF8, 16'h7FF8, 1'b1, 0, 16'h7FF8, 1'b1, 0};
    vecs[4] = '{16'h8000, 16'h7FF8, 16'h8000, 1'b1, 0, 16'h8000, 1'b1, 0};
    vecs[5] = '{16'h7FFC, 16'h000C, 16'h3FFF, 1'b0, 1, 16'h4007, 1'b0, 1};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1 rst = 1'b1;
    #2;
    check("reset state0", {out_valid0, in_ready0, ovf0, out_data0}, {3'b010, 16'h0000});
    check("reset state1", {out_valid1, in_ready1, ovf1, out_data1}, {3'b010, 16'h0000});
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 0,
             vecs[i].e0, vecs[i].o0, vecs[i].k0, vecs[i].e1, vecs[i].o1, vecs[i].k1);

    run_op("backpressure", 16'h7FF8, 16'h7FF8, 5, 16'h7FF8, 1'b1, 0, 16'h7FF8, 1'b1, 0);

    // Reset partway through MUL: outputs clear at once and the next operation is unaffected.
    @(negedge clk);
    a = 16'h0039; b = 16'h02A4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset out0", {out_valid0, in_ready0, ovf0, out_data0}, {3'b010, 16'h0000});
    check("midreset out1", {out_valid1, in_ready1, ovf1, out_data1}, {3'b010, 16'h0000});
    @(posedge clk);
    #2 rst = 1'b0;
    run_op("after reset", 16'h0039, 16'h02A4, 0, 16'h1265, 1'b0, 0, 16'h1265, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 1) ra[SW-1:0] = '0;
      if (i % 4 == 1) rb[SW-1:0] = '0;
      if (i % 5 == 2) rb = {13'h0001, rb[SW-1:0]};
      model(ra, rb, 0, e0, o0, k0);
      model(ra, rb, 1, e1, o1, k1);
      run_op($sformatf("rand%0d a=%h b=%h", i, ra, rb), ra, rb, 0, e0, o0, k0, e1, o1, k1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
